// File: rtl/camera_frame_sched.sv
// Once-per-frame view-vector scheduler: issues one start 1 cycle after new_frame, commits 1 cycle after done.
// No backpressure: frames arriving while busy coalesce into one pending issue; extras and timeouts count as misses.
module camera_frame_sched #(
  parameter int VEC_W          = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               new_frame_in,
  input  logic               freeze_in,
  input  logic [8:0]         pitch_in,
  input  logic [8:0]         roll_in,
  input  logic [8:0]         yaw_in,
  output logic               view_start_out,
  output logic [8:0]         view_pitch_out,
  output logic [8:0]         view_roll_out,
  output logic [8:0]         view_yaw_out,
  input  logic               view_done_in,
  input  logic [9*VEC_W-1:0] view_vec_in,
  output logic [9*VEC_W-1:0] cam_vec_out,
  output logic               cam_valid_out,
  output logic               cam_update_out,
  output logic               busy_out,
  output logic [7:0]         miss_count_out
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  logic [1:0]       state_q;
  logic [1:0]       state_nxt;
  logic             pending_q;
  logic             pending_nxt;
  logic [CNT_W-1:0] wait_cnt_q;

  logic       frame_req;
  logic       busy_now;
  logic       done_hit;
  logic       timeout;
  logic       exit_pt;
  logic       consume;
  logic       latch_ops;
  logic       pend_set;
  logic       coalesce;
  logic [8:0] miss_sum;

  always_comb begin
    frame_req = new_frame_in & ~freeze_in;
    busy_now  = (state_q != ST_IDLE);
    done_hit  = (state_q == ST_WAIT) && view_done_in;
    timeout   = (state_q == ST_WAIT) && !view_done_in && (wait_cnt_q == LAST_CNT);
    // A timeout leaves WAIT exactly like a COMMIT does, minus the vector update.
    exit_pt   = (state_q == ST_COMMIT) || timeout;
    consume   = exit_pt && pending_q;
    latch_ops = ((state_q == ST_IDLE) && frame_req) || consume;
    pend_set  = frame_req && busy_now;
    coalesce  = pend_set && pending_q;
    miss_sum  = {1'b0, miss_count_out} + {8'd0, timeout} + {8'd0, coalesce};
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:   if (frame_req) state_nxt = ST_ISSUE;
      ST_ISSUE:  state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (view_done_in)  state_nxt = ST_COMMIT;
        else if (timeout)  state_nxt = pending_q ? ST_ISSUE : ST_IDLE;
      end
      ST_COMMIT: state_nxt = pending_q ? ST_ISSUE : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // A frame landing in the same cycle a pending one is consumed keeps pending set.
  always_comb begin
    pending_nxt = pending_q;
    if (pend_set)     pending_nxt = 1'b1;
    else if (consume) pending_nxt = 1'b0;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q        <= ST_IDLE;
      pending_q      <= 1'b0;
      wait_cnt_q     <= '0;
      view_start_out <= 1'b0;
      busy_out       <= 1'b0;
      cam_update_out <= 1'b0;
    end else begin
      state_q        <= state_nxt;
      pending_q      <= pending_nxt;
      view_start_out <= (state_nxt == ST_ISSUE);
      busy_out       <= (state_nxt != ST_IDLE);
      cam_update_out <= (state_nxt == ST_COMMIT);
      if (state_q == ST_ISSUE)
        wait_cnt_q <= '0;
      else if ((state_q == ST_WAIT) && !view_done_in && !timeout)
        wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      view_pitch_out <= '0;
      view_roll_out  <= '0;
      view_yaw_out   <= '0;
    end else if (latch_ops) begin
      view_pitch_out <= pitch_in;
      view_roll_out  <= roll_in;
      view_yaw_out   <= yaw_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cam_vec_out    <= '0;
      cam_valid_out  <= 1'b0;
      miss_count_out <= '0;
    end else begin
      if (done_hit) begin
        cam_vec_out   <= view_vec_in;
        cam_valid_out <= 1'b1;
      end
      miss_count_out <= miss_sum[8] ? 8'hFF : miss_sum[7:0];
    end
  end

endmodule

// File: tb/tb_camera_frame_sched.sv
// Directed bench for camera_frame_sched: operand and vector scoreboards checked on every start/update pulse.
module tb_camera_frame_sched;

  localparam int VEC_W = 32;
  localparam int TO    = 8;

  logic               clk_in = 1'b0;
  logic               rst_n_in;
  logic               new_frame_in;
  logic               freeze_in;
  logic [8:0]         pitch_in, roll_in, yaw_in;
  logic               view_start_out;
  logic [8:0]         view_pitch_out, view_roll_out, view_yaw_out;
  logic               view_done_in;
  logic [9*VEC_W-1:0] view_vec_in;
  logic [9*VEC_W-1:0] cam_vec_out;
  logic               cam_valid_out;
  logic               cam_update_out;
  logic               busy_out;
  logic [7:0]         miss_count_out;

  camera_frame_sched #(.VEC_W(VEC_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .new_frame_in   (new_frame_in),
    .freeze_in      (freeze_in),
    .pitch_in       (pitch_in),
    .roll_in        (roll_in),
    .yaw_in         (yaw_in),
    .view_start_out (view_start_out),
    .view_pitch_out (view_pitch_out),
    .view_roll_out  (view_roll_out),
    .view_yaw_out   (view_yaw_out),
    .view_done_in   (view_done_in),
    .view_vec_in    (view_vec_in),
    .cam_vec_out    (cam_vec_out),
    .cam_valid_out  (cam_valid_out),
    .cam_update_out (cam_update_out),
    .busy_out       (busy_out),
    .miss_count_out (miss_count_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;
  logic [26:0]        op_q[$];
  logic [9*VEC_W-1:0] vec_q[$];
  logic [9*VEC_W-1:0] vec_a, vec_b, vec_c, vec_d, vec_e;
  logic [7:0]         exp_miss;

  task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic logic [9*VEC_W-1:0] mkvec(input int seed);
    logic [9*VEC_W-1:0] v;
    for (int k = 0; k < 9; k++) v[k*VEC_W +: VEC_W] = seed * 32'h01010101 + k * 32'h11;
    return v;
  endfunction

  // Advance one cycle, then score any start/update pulse against the queues.
  task automatic tick();
    @(posedge clk_in);
    #1;
    if (view_start_out) begin
      if (op_q.size() == 0) chk("start_unexpected", view_start_out, 0);
      else chk("operands", {view_pitch_out, view_roll_out, view_yaw_out}, op_q.pop_front());
    end
    if (cam_update_out) begin
      if (vec_q.size() == 0) chk("update_unexpected", cam_update_out, 0);
      else chk("cam_vec", cam_vec_out, vec_q.pop_front());
    end
  endtask

  task automatic issue(input logic [8:0] p, input logic [8:0] r, input logic [8:0] y);
    pitch_in = p; roll_in = r; yaw_in = y;
    new_frame_in = 1'b1;
    op_q.push_back({p, r, y});
  endtask

  initial begin
    rst_n_in = 1'b0; new_frame_in = 1'b0; freeze_in = 1'b0;
    pitch_in = '0; roll_in = '0; yaw_in = '0;
    view_done_in = 1'b0; view_vec_in = '0;
    vec_a = mkvec(1); vec_b = mkvec(2); vec_c = mkvec(3); vec_d = mkvec(4); vec_e = mkvec(5);
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_cam_vec", cam_vec_out, 0);
    chk("rst_flags", {cam_valid_out, cam_update_out, view_start_out, busy_out}, 0);
    chk("rst_ops_miss", {view_pitch_out, view_roll_out, view_yaw_out, miss_count_out}, 0);
    rst_n_in = 1'b1;
    tick();

    // Basic frame: start one cycle after new_frame, done in 4th WAIT cycle.
    issue(9'd5, 9'd7, 9'd9);
    tick();
    new_frame_in = 1'b0;
    chk("t1_start", view_start_out, 1);
    chk("t1_busy", busy_out, 1);
    tick();
    chk("t1_start_once", view_start_out, 0);
    repeat (3) tick();
    view_done_in = 1'b1; view_vec_in = vec_a; vec_q.push_back(vec_a);
    tick();
    view_done_in = 1'b0;
    chk("t1_update", cam_update_out, 1);
    chk("t1_valid", cam_valid_out, 1);
    chk("t1_miss", miss_count_out, 0);
    tick();
    chk("t1_idle", {busy_out, cam_update_out}, 0);

    // Timeout after exactly TO wait cycles.
    issue(9'd1, 9'd1, 9'd1);
    tick();
    new_frame_in = 1'b0;
    repeat (TO) tick();
    chk("t2_busy_last_wait", busy_out, 1);
    chk("t2_miss_before", miss_count_out, 0);
    tick();
    chk("t2_busy_after", busy_out, 0);
    chk("t2_miss_after", miss_count_out, 1);
    chk("t2_cam_vec_kept", cam_vec_out, vec_a);
    chk("t2_no_update", cam_update_out, 0);

    // Two frames during WAIT: one pending issue with fresh operands, one miss.
    issue(9'd1, 9'd2, 9'd3);
    tick();
    new_frame_in = 1'b0;
    tick();
    pitch_in = 9'd10; roll_in = 9'd11; yaw_in = 9'd12; new_frame_in = 1'b1;
    tick();
    new_frame_in = 1'b0;
    tick();
    pitch_in = 9'd20; roll_in = 9'd21; yaw_in = 9'd22; new_frame_in = 1'b1;
    tick();
    new_frame_in = 1'b0;
    chk("t3_miss_coalesce", miss_count_out, 2);
    view_done_in = 1'b1; view_vec_in = vec_b; vec_q.push_back(vec_b);
    op_q.push_back({9'd20, 9'd21, 9'd22});
    tick();
    view_done_in = 1'b0;
    chk("t3_commit", {cam_update_out, busy_out}, 2'b11);
    tick();
    chk("t3_pending_start", view_start_out, 1);
    tick();
    view_done_in = 1'b1; view_vec_in = vec_c; vec_q.push_back(vec_c);
    tick();
    view_done_in = 1'b0;
    chk("t3_min_latency_update", cam_update_out, 1);
    tick();
    chk("t3_idle", busy_out, 0);
    chk("t3_miss_final", miss_count_out, 2);

    // Done coincides with the last WAIT cycle: done wins.
    issue(9'd3, 9'd3, 9'd3);
    tick();
    new_frame_in = 1'b0;
    repeat (TO) tick();
    view_done_in = 1'b1; view_vec_in = vec_d; vec_q.push_back(vec_d);
    tick();
    view_done_in = 1'b0;
    chk("t4_update", cam_update_out, 1);
    chk("t4_miss", miss_count_out, 2);
    chk("t4_cam_vec", cam_vec_out, vec_d);
    tick();
    chk("t4_idle", busy_out, 0);

    // Freeze masks frames; spurious done in IDLE is ignored.
    freeze_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      new_frame_in = 1'b1;
      tick();
      new_frame_in = 1'b0;
      chk("t5_frozen", {view_start_out, busy_out, cam_update_out}, 0);
      tick();
    end
    chk("t5_miss", miss_count_out, 2);
    freeze_in = 1'b0;
    view_done_in = 1'b1; view_vec_in = vec_e;
    tick();
    view_done_in = 1'b0;
    chk("t5_spurious_vec", cam_vec_out, vec_d);
    chk("t5_spurious_update", cam_update_out, 0);

    // Reset in WAIT discards the computation.
    issue(9'd4, 9'd4, 9'd4);
    tick();
    new_frame_in = 1'b0;
    tick();
    rst_n_in = 1'b0;
    #1;
    chk("t6_rst_cam_vec", cam_vec_out, 0);
    chk("t6_rst_flags", {cam_valid_out, cam_update_out, view_start_out, busy_out}, 0);
    chk("t6_rst_ops_miss", {view_pitch_out, view_roll_out, view_yaw_out, miss_count_out}, 0);
    #2;
    rst_n_in = 1'b1;
    tick();
    view_done_in = 1'b1; view_vec_in = vec_e;
    tick();
    view_done_in = 1'b0;
    chk("t6_no_commit", {cam_update_out, cam_valid_out, busy_out}, 0);
    chk("t6_cam_vec_zero", cam_vec_out, 0);

    // Back-to-back timeouts: miss counter saturates.
    exp_miss = 8'd0;
    for (int i = 0; i < 300; i++) begin
      int k;
      issue(9'(i), 9'(i + 1), 9'(i + 2));
      tick();
      new_frame_in = 1'b0;
      k = 0;
      while (busy_out && k < 4 * TO) begin
        tick();
        k++;
      end
      if (busy_out) begin
        chk("t7_idle_bound", busy_out, 0);
        break;
      end
      if (exp_miss != 8'hFF) exp_miss = exp_miss + 8'd1;
      chk("t7_miss", miss_count_out, exp_miss);
    end
    chk("t7_saturated", miss_count_out, 8'hFF);

    chk("op_queue_drained", op_q.size(), 0);
    chk("vec_queue_drained", vec_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
